// File: rtl/cell_plot_queue.sv
// cell_plot_queue: buffers (x, y, colour) game-grid cell commands in a small
// FIFO and expands each into a CELL_W x CELL_H rectangle of single-pixel
// writes on the VGA adapter port, row-major and top-left first.
// Optional build macro CELL_BORDER_EN: paints the outline pixels of every
// cell black so grid segments are visibly separated.
module cell_plot_queue #(
    parameter int CELL_W     = 10,
    parameter int CELL_H     = 7,
    parameter int X_ORIGIN   = 0,
    parameter int Y_ORIGIN   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] game_x,
    input  logic [3:0] game_y,
    input  logic [2:0] game_colour,
    output logic       waitrequest,
    output logic       busy,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]       COL_LAST = 4'(CELL_W - 1);
    localparam logic [2:0]       ROW_LAST = 3'(CELL_H - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] c;
    } cmd_t;

    state_t           state_q, state_d;
    logic             rst_q, rst_d;
    cmd_t             mem_q [FIFO_DEPTH];
    cmd_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [3:0]       wx_q, wx_d;
    logic [3:0]       wy_q, wy_d;
    logic [2:0]       wc_q, wc_d;
    logic [3:0]       col_q, col_d;
    logic [2:0]       row_q, row_d;
    logic             vga_plot_q, vga_plot_d;
    logic [7:0]       vga_x_q, vga_x_d;
    logic [6:0]       vga_y_q, vga_y_d;
    logic [2:0]       vga_colour_q, vga_colour_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    cmd_t head;

    // Handshake and status come only from registered state, so the initiator
    // never sees a combinational path from its own start back to waitrequest.
    always_comb begin
        fifo_full   = (count_q == CNT_FULL);
        fifo_empty  = (count_q == '0);
        waitrequest = rst_q | fifo_full;
        busy        = (state_q == DRAW) | ~fifo_empty;
        push        = start & ~waitrequest;
        head        = mem_q[rd_ptr_q];
        rst_d       = rst;
        vga_plot    = vga_plot_q;
        vga_x       = vga_x_q;
        vga_y       = vga_y_q;
        vga_colour  = vga_colour_q;
    end

    // Rectangle walker: pops a command when idle or on the last pixel of the
    // current cell, so queued cells follow each other with no gap.
    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wc_d    = wc_q;
        col_d   = col_q;
        row_d   = row_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wx_d    = head.x;
                    wy_d    = head.y;
                    wc_d    = head.c;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            wx_d = head.x;
                            wy_d = head.y;
                            wc_d = head.c;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel outputs are computed from the next walker position so the
    // registered strobe lines up with the pixel being presented; the
    // parameter limits keep the address sums inside the 8/7-bit ranges.
    always_comb begin
        vga_plot_d   = (state_d == DRAW);
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        if (state_d == DRAW) begin
            vga_x_d = 8'(X_ORIGIN) + 8'(wx_d) * 8'(CELL_W) + 8'(col_d);
            vga_y_d = 7'(Y_ORIGIN) + 7'(wy_d) * 7'(CELL_H) + 7'(row_d);
`ifdef CELL_BORDER_EN
            if ((col_d == '0) || (col_d == COL_LAST) ||
                (row_d == '0) || (row_d == ROW_LAST)) begin
                vga_colour_d = 3'b000;
            end else begin
                vga_colour_d = wc_d;
            end
`else
            vga_colour_d = wc_d;
`endif
        end
    end

    // Command FIFO bookkeeping; a same-edge push and pop leaves occupancy alone.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{x: game_x, y: game_y, c: game_colour};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // FIFO storage needs no reset: occupancy and pointers decide validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state; reset drops any queued or in-flight cell immediately.
    always_ff @(posedge clk) begin
        rst_q <= rst_d;
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            wc_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            wc_q         <= wc_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vga_plot_q   <= vga_plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

endmodule

// File: tb/tb_cell_plot_queue.sv
// Bench for cell_plot_queue: a directed vector table for the first cell,
// hand-written corner sequences, and random command streams, all compared
// every cycle against a pixel-list reference model.
module tb_cell_plot_queue;

    localparam int CELL_W     = 10;
    localparam int CELL_H     = 7;
    localparam int X_ORIGIN   = 0;
    localparam int Y_ORIGIN   = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef CELL_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] game_x;
    logic [3:0] game_y;
    logic [2:0] game_colour;
    logic       waitrequest;
    logic       busy;
    logic       vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int errors = 0;

    cell_plot_queue #(
        .CELL_W    (CELL_W),
        .CELL_H    (CELL_H),
        .X_ORIGIN  (X_ORIGIN),
        .Y_ORIGIN  (Y_ORIGIN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .game_x     (game_x),
        .game_y     (game_y),
        .game_colour(game_colour),
        .waitrequest(waitrequest),
        .busy       (busy),
        .vga_plot   (vga_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending commands and the list of pixels still to show.
    typedef struct {
        int x;
        int y;
        int c;
    } item_t;

    item_t mq[$];
    item_t pq[$];
    bit    m_rst   = 1'b0;
    bit    m_valid = 1'b0;
    int    m_lx = 0, m_ly = 0, m_lc = 0;

    function automatic void expand(input item_t cmd);
        for (int r = 0; r < CELL_H; r++) begin
            for (int c = 0; c < CELL_W; c++) begin
                item_t p;
                p.x = X_ORIGIN + cmd.x * CELL_W + c;
                p.y = Y_ORIGIN + cmd.y * CELL_H + r;
                if (BORDER && (c == 0 || c == CELL_W - 1 || r == 0 || r == CELL_H - 1))
                    p.c = 0;
                else
                    p.c = cmd.c;
                pq.push_back(p);
            end
        end
    endfunction

    always @(posedge clk) begin
        bit    m_wait;
        bit    acc;
        bit    do_pop;
        item_t cmd;
        m_wait = m_rst || (mq.size() == FIFO_DEPTH);
        if (rst === 1'b1) begin
            mq.delete();
            pq.delete();
            m_rst   = 1'b1;
            m_valid = 1'b1;
            m_lx = 0; m_ly = 0; m_lc = 0;
        end else begin
            acc    = (start === 1'b1) && !m_wait;
            do_pop = (pq.size() <= 1) && (mq.size() > 0);
            if (pq.size() > 0) void'(pq.pop_front());
            if (do_pop) expand(mq.pop_front());
            if (acc) begin
                cmd.x = int'(game_x);
                cmd.y = int'(game_y);
                cmd.c = int'(game_colour);
                mq.push_back(cmd);
            end
            m_rst = 1'b0;
            if (pq.size() > 0) begin
                m_lx = pq[0].x; m_ly = pq[0].y; m_lc = pq[0].c;
            end
        end
    end

    // Every cycle after reset, the DUT outputs must follow the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check_output("model_plot", 32'(vga_plot), 32'(pq.size() > 0));
            check_output("model_busy", 32'(busy), 32'((pq.size() > 0) || (mq.size() > 0)));
            check_output("model_wait", 32'(waitrequest), 32'(m_rst || (mq.size() == FIFO_DEPTH)));
            check_output("model_x", 32'(vga_x), 32'(m_lx));
            check_output("model_y", 32'(vga_y), 32'(m_ly));
            check_output("model_colour", 32'(vga_colour), 32'(m_lc));
        end
    end

    // Plot statistics used by the scenario checks.
    int cyc = 0, plots = 0, first_cyc = 0, last_cyc = 0;
    int min_x, max_x, min_y, max_y, last_x, last_y, c010;
    int col_10_11, col_11_12;
    bit saw_wait;

    task automatic clear_stats();
        plots = 0; first_cyc = 0; last_cyc = 0;
        min_x = 999; max_x = -1; min_y = 999; max_y = -1;
        last_x = -1; last_y = -1; c010 = 0;
        col_10_11 = -1; col_11_12 = -1;
        saw_wait = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (vga_plot === 1'b1) begin
            plots++;
            if (plots == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (int'(vga_x) < min_x) min_x = int'(vga_x);
            if (int'(vga_x) > max_x) max_x = int'(vga_x);
            if (int'(vga_y) < min_y) min_y = int'(vga_y);
            if (int'(vga_y) > max_y) max_y = int'(vga_y);
            last_x = int'(vga_x);
            last_y = int'(vga_y);
            if (vga_colour == 3'b010) c010++;
            if (vga_x == 8'd10 && vga_y == 7'd11) col_10_11 = int'(vga_colour);
            if (vga_x == 8'd11 && vga_y == 7'd12) col_11_12 = int'(vga_colour);
        end
    end

    // Holds start until a cycle with waitrequest low, then drops it.
    task automatic apply_stimulus(input int x, input int y, input int c);
        bit ok;
        bit w;
        ok = 1'b0;
        game_x = 4'(x); game_y = 4'(y); game_colour = 3'(c);
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            w = waitrequest;
            if (w) saw_wait = 1'b1;
            @(negedge clk);
            if (!w) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) check_output("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_output("idle_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit       rst;
        bit       start;
        int       gx, gy, gc;
        bit       ew, eb, ep;
        int       ex, ey, ec;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int saved;
        rst = 1'b1; start = 1'b0; game_x = '0; game_y = '0; game_colour = '0;
        clear_stats();

        // Single cell (12,12) colour 100: reset, held start, then first pixels.
        vecs[0] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 12, 12, 4, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 12, 12, 4, 0, 1, 0, 0, 0, 0};
        vecs[3] = '{0, 0, 12, 12, 4, 0, 1, 1, 120, 88, BORDER ? 0 : 4};
        vecs[4] = '{0, 0, 12, 12, 4, 0, 1, 1, 121, 88, BORDER ? 0 : 4};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rst = vecs[i].rst;
            start = vecs[i].start;
            game_x = 4'(vecs[i].gx); game_y = 4'(vecs[i].gy); game_colour = 3'(vecs[i].gc);
            @(negedge clk);
            check_output($sformatf("vec%0d_wait", i), 32'(waitrequest), 32'(vecs[i].ew));
            check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
            check_output($sformatf("vec%0d_plot", i), 32'(vga_plot), 32'(vecs[i].ep));
            check_output($sformatf("vec%0d_x", i), 32'(vga_x), 32'(vecs[i].ex));
            check_output($sformatf("vec%0d_y", i), 32'(vga_y), 32'(vecs[i].ey));
            check_output($sformatf("vec%0d_colour", i), 32'(vga_colour), 32'(vecs[i].ec));
        end
        wait_idle();
        check_output("single_plots", 32'(plots), 32'd70);
        check_output("single_last_x", 32'(last_x), 32'd129);
        check_output("single_last_y", 32'(last_y), 32'd94);
        check_output("single_end_plot", 32'(vga_plot), 32'd0);

        // Corner cells.
        clear_stats();
        apply_stimulus(0, 0, 5);
        wait_idle();
        check_output("c00_plots", 32'(plots), 32'd70);
        check_output("c00_min_x", 32'(min_x), 32'd0);
        check_output("c00_max_x", 32'(max_x), 32'd9);
        check_output("c00_min_y", 32'(min_y), 32'd4);
        check_output("c00_max_y", 32'(max_y), 32'd10);
        clear_stats();
        apply_stimulus(15, 15, 7);
        wait_idle();
        check_output("c1515_plots", 32'(plots), 32'd70);
        check_output("c1515_min_x", 32'(min_x), 32'd150);
        check_output("c1515_max_x", 32'(max_x), 32'd159);
        check_output("c1515_min_y", 32'(min_y), 32'd109);
        check_output("c1515_max_y", 32'(max_y), 32'd115);

        // Six back-to-back commands fill the FIFO; pixels must be gap-free.
        clear_stats();
        for (int i = 0; i < 6; i++) apply_stimulus(i + 2, 15 - i, i + 1);
        wait_idle();
        check_output("full_saw_wait", 32'(saw_wait), 32'd1);
        check_output("full_plots", 32'(plots), 32'd420);
        check_output("full_span", 32'(last_cyc - first_cyc + 1), 32'd420);

        // Reset on the 30th plot cycle of the first of three queued cells.
        clear_stats();
        for (int i = 0; i < 3; i++) apply_stimulus(i, i, 3);
        for (int i = 0; i < 500; i++) begin
            if (plots >= 30) break;
            @(negedge clk);
            #1;
        end
        check_output("rst_reached_30", 32'(plots), 32'd30);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_output("rst_plot_low", 32'(vga_plot), 32'd0);
        rst = 1'b0;
        saved = plots;
        repeat (150) @(negedge clk);
        #1;
        check_output("rst_no_more_plots", 32'(plots), 32'(saved));
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_wait", 32'(waitrequest), 32'd0);

        // Colour rule on cell (1,1) colour 010.
        clear_stats();
        apply_stimulus(1, 1, 2);
        wait_idle();
        check_output("col_count_010", 32'(c010), BORDER ? 32'd40 : 32'd70);
        check_output("col_pix_10_11", 32'(col_10_11), BORDER ? 32'd0 : 32'd2);
        check_output("col_pix_11_12", 32'(col_11_12), 32'd2);

        // Random command stream with random idle gaps.
        clear_stats();
        for (int n = 0; n < 15; n++) begin
            apply_stimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check_output("rand_plots", 32'(plots), 32'd1050);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
